// File: rtl/ripple_adder3.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_adder3 (with leaf ripple_adder3_fa)
//  Description : Registered 3-bit ripple-carry adder built from three chained
//                full-adder instances. The sum, the carry-out of every stage
//                and the signed overflow are registered one clock after the
//                operands are presented with in_valid.
//  Ports       : clk       - system clock, rising-edge active
//                reset     - synchronous, active-high clear of all outputs
//                in_valid  - a/b/cin hold a valid operation this cycle
//                a, b      - 3-bit addends (unsigned / two's complement)
//                cin       - carry into bit 0
//                sum       - registered sum bits
//                cout      - registered per-stage carry-outs (cout[2] final)
//                overflow  - registered signed overflow (cout[2] ^ cout[1])
//                out_valid - outputs hold the result of a valid operation
//  Revision    : 1.0 - initial release
// ============================================================================

// Single full-adder stage.
module ripple_adder3_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module ripple_adder3 (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] sum,
  output logic [2:0] cout,
  output logic       overflow,
  output logic       out_valid
);

  // carry[i] is the carry into stage i; carry[i+1] is that stage's carry-out.
  logic [3:0] w_carry;
  logic [2:0] w_sum;
  logic [2:0] w_cout;
  logic       w_overflow;

  logic [2:0] sum_d,       sum_q;
  logic [2:0] cout_d,      cout_q;
  logic       overflow_d,  overflow_q;
  logic       out_valid_d, out_valid_q;

  assign w_carry[0] = cin;

  // Three stages wired strictly in ripple order; no lookahead.
  generate
    for (genvar i = 0; i < 3; i++) begin : g_stage
      ripple_adder3_fa u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (w_carry[i]),
        .s  (w_sum[i]),
        .co (w_carry[i+1])
      );
    end
  endgenerate

  assign w_cout = w_carry[3:1];

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  assign w_overflow = w_cout[2] ^ w_cout[1];

  // Result registers load only on valid operations and otherwise hold;
  // out_valid simply tracks whether the previous edge carried an operation.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d      = w_sum;
      cout_d     = w_cout;
      overflow_d = w_overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q       <= 3'b000;
      cout_q      <= 3'b000;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ripple_adder3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ripple_adder3
//  Description : Self-checking bench for ripple_adder3. An arithmetic model
//                predicts every registered output; directed vectors with
//                literal expectations pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_adder3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] a, b;
  logic       cin;
  logic [2:0] sum, cout;
  logic       overflow, out_valid;

  int n_total = 0;
  int n_pass  = 0;

  ripple_adder3 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic       m_known = 1'b0;
  logic [2:0] m_sum, m_cout;
  logic       m_ovf, m_valid;

  always @(posedge clk) begin
    int full, part, sa, sb, ss;
    if (reset) begin
      m_known = 1'b1;
      m_sum = 3'd0; m_cout = 3'd0; m_ovf = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        full  = int'(a) + int'(b) + int'(cin);
        m_sum = full[2:0];
        // carry out of bit i = bit i+1 of the sum of the low i+1 bits
        for (int i = 0; i < 3; i++) begin
          part = int'(a & 3'((1 << (i + 1)) - 1)) + int'(b & 3'((1 << (i + 1)) - 1)) + int'(cin);
          m_cout[i] = part[i+1];
        end
        sa = a[2] ? int'(a) - 8 : int'(a);
        sb = b[2] ? int'(b) - 8 : int'(b);
        ss = sa + sb + int'(cin);
        m_ovf = (ss > 3) || (ss < -4);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_known) begin
      chk("sum",       {1'b0, sum},    {1'b0, m_sum});
      chk("cout",      {1'b0, cout},   {1'b0, m_cout});
      chk("overflow",  {3'b0, overflow},  {3'b0, m_ovf});
      chk("out_valid", {3'b0, out_valid}, {3'b0, m_valid});
    end
  end

  // Present one valid operation at a negedge, then check the literal result
  // at the following negedge.
  task automatic op(input logic [2:0] ta, input logic [2:0] tb, input logic tc,
                    input logic [2:0] es, input logic [2:0] ec, input logic eo);
    in_valid = 1'b1; a = ta; b = tb; cin = tc;
    @(negedge clk);
    chk("lit_sum",   {1'b0, sum},  {1'b0, es});
    chk("lit_cout",  {1'b0, cout}, {1'b0, ec});
    chk("lit_ovf",   {3'b0, overflow},  {3'b0, eo});
    chk("lit_valid", {3'b0, out_valid}, 4'd1);
  endtask

  initial begin
    // Reset with a valid-looking operation present: must be discarded.
    reset = 1'b1; in_valid = 1'b1; a = 3'd7; b = 3'd7; cin = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sum",   {1'b0, sum},  4'd0);
    chk("rst_cout",  {1'b0, cout}, 4'd0);
    chk("rst_ovf",   {3'b0, overflow},  4'd0);
    chk("rst_valid", {3'b0, out_valid}, 4'd0);
    reset = 1'b0;

    op(3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
    op(3'b011, 3'b101, 1'b0, 3'b000, 3'b111, 1'b0);
    op(3'b111, 3'b111, 1'b1, 3'b111, 3'b111, 1'b0);
    op(3'b010, 3'b001, 1'b0, 3'b011, 3'b000, 1'b0);
    op(3'b100, 3'b100, 1'b0, 3'b000, 3'b100, 1'b1);
    op(3'b011, 3'b001, 1'b0, 3'b100, 3'b011, 1'b1);

    // Hold: idle inputs must not disturb the last result.
    in_valid = 1'b0; a = 3'b101; b = 3'b110; cin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_sum",   {1'b0, sum},  4'b0100);
      chk("hold_cout",  {1'b0, cout}, 4'b0011);
      chk("hold_ovf",   {3'b0, overflow},  4'd1);
      chk("hold_valid", {3'b0, out_valid}, 4'd0);
    end

    // Mid-stream reset discards the operation presented with it.
    in_valid = 1'b1; a = 3'd6; b = 3'd5; cin = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_sum",   {1'b0, sum},  4'd0);
    chk("midrst_valid", {3'b0, out_valid}, 4'd0);

    // Exhaustive back-to-back sweep; the per-cycle compare checks each.
    for (int v = 0; v < 128; v++) begin
      in_valid = 1'b1;
      {a, b, cin} = 7'(v);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ripple_adder3.md
# ripple_adder3

Registered 3-bit ripple-carry adder built from three chained full-adder stages. It exposes the sum and the carry-out of every stage, so downstream logic and the bench can observe carry propagation bit by bit. It is a small datapath leaf in the pre/P1 arithmetic set; results are registered one clock after the operands are captured.

## Interface
- No parameters; width fixed at 3 bits.
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all registered outputs.
- in_valid  input  1  operands on a/b/cin are valid this cycle.
- a  input  3  addend A, unsigned (also interpreted two's-complement for `overflow`).
- b  input  3  addend B.
- cin  input  1  carry into bit 0.
- sum  output  3  registered sum bits; sum[i] = a[i] ^ b[i] ^ c[i].
- cout  output  3  registered per-stage carry-outs; cout[i] = carry out of bit i; cout[2] is the final carry.
- overflow  output  1  registered signed overflow, cout[2] ^ cout[1].
- out_valid  output  1  sum/cout/overflow hold the result of a valid operation.

## Operation
- Stage chain: c[0] = cin; c[i+1] = cout[i]. Each stage is a full adder: s = a^b^c, co = (a&b) | (a&c) | (b&c).
- Stages are instantiated as three separate full-adder instances wired in ripple order; no carry-lookahead.
- Full result as a 4-bit value: {cout[2], sum} = a + b + cin (range 0..15).
- On a rising edge with in_valid=1: sum, cout, overflow registers load the combinational results of the current a, b, cin; out_valid <= 1.
- On a rising edge with in_valid=0: sum, cout, overflow hold previous values; out_valid <= 0.
- Operands are not separately registered; they are sampled only at the edge where in_valid=1.
- No X propagation requirements beyond standard: with in_valid=0, a/b/cin values are don't-care.

## Timing
- Latency: 1 clock. Operands valid at edge N appear on outputs after edge N; out_valid high for exactly the cycles following valid inputs.
- Throughput: one operation per clock; back-to-back in_valid cycles produce back-to-back results.
- Reset (synchronous, active-high, highest priority): at a rising edge with reset=1, sum=3'b000, cout=3'b000, overflow=0, out_valid=0, regardless of in_valid.
- Reset asserted mid-stream discards the operation presented in that cycle; the first result after reset deasserts comes from the first in_valid edge with reset=0.
- Power-up before the first reset edge: outputs undefined; bench must apply reset for at least 1 cycle.
- Combinational path is a[0]/b[0]/cin -> three carry stages -> output register D; no combinational path from inputs to outputs.

## Test plan
- Reset: reset=1 for 2 cycles with in_valid=1, a=7, b=7, cin=1 -> sum=000, cout=000, overflow=0, out_valid=0.
- Zero: a=000, b=000, cin=0, in_valid=1 -> next cycle sum=000, cout=000, overflow=0, out_valid=1.
- Full carry ripple: a=011, b=101, cin=0 -> sum=000, cout=111, overflow=0; then a=111, b=111, cin=1 -> sum=111, cout=111, overflow=0.
- Partial carries/overflow: a=010, b=001, cin=0 -> sum=011, cout=000, overflow=0; a=100, b=100, cin=0 -> sum=000, cout=100, overflow=1; a=011, b=001, cin=0 -> sum=100, cout=011, overflow=1.
- Hold: after a valid result, drive in_valid=0 with a=101, b=110 for 3 cycles -> sum/cout/overflow unchanged, out_valid=0.
- Exhaustive: all 128 (a, b, cin) combinations back-to-back with in_valid=1 -> each result one cycle later matches {cout[2], sum} = a+b+cin, each cout[i] matches the reference carry chain, out_valid=1 throughout.
